xcvr_ref_clk_monitor: RTL and testbench

Multi-channel qualifier for transceiver reference clocks. It samples NUM_CH pre-divided reference clocks (REF_DIV_IN, e.g. REFCLK/64 from fabric dividers) in the CLK domain and counts rising edges per fixed measurement window. It declares each channel LOCKED or LOST using consecutive-window hysteresis and raises a sticky loss flag. It sits between the XCVR_REF_CLK buffers and the transceiver/PLL reset sequencer, gating PLL release until the reference is qualified.

---
 rtl/xcvr_ref_clk_pkg.sv | 27 ++
 rtl/xcvr_ref_clk_chan_mon.sv | 117 +++++++++++
 rtl/xcvr_ref_clk_monitor.sv | 64 ++++++
 tb/tb_xcvr_ref_clk_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/xcvr_ref_clk_pkg.sv
// rtl/xcvr_ref_clk_pkg.sv - shared types and helpers for the reference clock monitor
package xcvr_ref_clk_pkg;

    typedef enum logic [1:0] {
        ST_LOST    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } chan_state_e;

    localparam int unsigned SYNC_STAGES = 2;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Lower bound clamps at zero so a tolerance wider than the target never wraps.
    function automatic logic in_range(input logic [31:0] count,
                                      input int unsigned exp_count,
                                      input int unsigned tol);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = (exp_count > tol) ? exp_count - tol : 32'd0;
        hi = exp_count + tol;
        return (count >= lo) && (count <= hi);
    endfunction

endpackage

// File: rtl/xcvr_ref_clk_chan_mon.sv
// rtl/xcvr_ref_clk_chan_mon.sv - per-channel edge counter, lock FSM and sticky loss flag
module xcvr_ref_clk_chan_mon
    import xcvr_ref_clk_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned EXP_COUNT    = 64,
    parameter int unsigned TOL          = 2,
    parameter int unsigned LOCK_WINDOWS = 4,
    parameter int unsigned LOSS_WINDOWS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ref_div_i,
    input  logic             clear_loss_i,
    input  logic             win_end_i,
    output logic             locked_o,
    output logic             loss_o,
    output logic [CNT_W-1:0] freq_count_o
);

    localparam int unsigned       GOOD_W   = cnt_width(LOCK_WINDOWS);
    localparam int unsigned       BAD_W    = cnt_width(LOSS_WINDOWS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_WINDOWS);
    localparam logic [BAD_W-1:0]  BAD_TGT  = BAD_W'(LOSS_WINDOWS);

    logic [SYNC_STAGES:0] sync_q;
    logic                 edge_det;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0]     freq_q, freq_d;
    chan_state_e          state_q, state_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic                 loss_q, loss_d, loss_set;
    logic                 win_in_range;

    assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

    // An edge seen on the terminal cycle is folded into the count being evaluated.
    assign cnt_inc      = (edge_det && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    assign cnt_d        = win_end_i ? '0 : cnt_inc;
    assign freq_d       = win_end_i ? cnt_inc : freq_q;
    assign win_in_range = in_range(32'(cnt_inc), EXP_COUNT, TOL);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        bad_d    = bad_q;
        loss_set = 1'b0;
        if (win_end_i) begin
            case (state_q)
                ST_LOST: begin
                    if (win_in_range) begin
                        good_d  = GOOD_W'(1);
                        bad_d   = '0;
                        state_d = (LOCK_WINDOWS <= 1) ? ST_LOCKED : ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (!win_in_range) begin
                        good_d  = '0;
                        state_d = ST_LOST;
                    end else if (good_q + GOOD_W'(1) >= GOOD_TGT) begin
                        bad_d   = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (cnt_inc == '0 || (!win_in_range && bad_q + BAD_W'(1) >= BAD_TGT)) begin
                        good_d   = '0;
                        bad_d    = '0;
                        loss_set = 1'b1;
                        state_d  = ST_LOST;
                    end else if (win_in_range) begin
                        bad_d = '0;
                    end else begin
                        bad_d = bad_q + BAD_W'(1);
                    end
                end
                default: begin
                    good_d  = '0;
                    bad_d   = '0;
                    state_d = ST_LOST;
                end
            endcase
        end
    end

    assign loss_d = loss_set ? 1'b1 : (clear_loss_i ? 1'b0 : loss_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            freq_q  <= '0;
            state_q <= ST_LOST;
            good_q  <= '0;
            bad_q   <= '0;
            loss_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-1:0], ref_div_i};
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            loss_q  <= loss_d;
        end
    end

    assign locked_o     = (state_q == ST_LOCKED);
    assign loss_o       = loss_q;
    assign freq_count_o = freq_q;

endmodule

// File: rtl/xcvr_ref_clk_monitor.sv
// rtl/xcvr_ref_clk_monitor.sv - multi-channel reference clock qualifier with shared measurement window
module xcvr_ref_clk_monitor
    import xcvr_ref_clk_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned WINDOW_CYCLES = 4096,
    parameter int unsigned EXP_COUNT     = 64,
    parameter int unsigned TOL           = 2,
    parameter int unsigned LOCK_WINDOWS  = 4,
    parameter int unsigned LOSS_WINDOWS  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       ref_div_i,
    input  logic [NUM_CH-1:0]       clear_loss_i,
    output logic [NUM_CH-1:0]       locked_o,
    output logic [NUM_CH-1:0]       loss_o,
    output logic [NUM_CH*CNT_W-1:0] freq_count_o,
    output logic                    count_valid_o
);

    localparam int unsigned      WIN_W    = cnt_width(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic [WIN_W-1:0] win_q, win_d;
    logic             win_end;
    logic             count_valid_q;

    assign win_end = (win_q == WIN_LAST);
    assign win_d   = win_end ? '0 : win_q + WIN_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q         <= '0;
            count_valid_q <= 1'b0;
        end else begin
            win_q         <= win_d;
            count_valid_q <= win_end;
        end
    end

    assign count_valid_o = count_valid_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        xcvr_ref_clk_chan_mon #(
            .CNT_W        (CNT_W),
            .EXP_COUNT    (EXP_COUNT),
            .TOL          (TOL),
            .LOCK_WINDOWS (LOCK_WINDOWS),
            .LOSS_WINDOWS (LOSS_WINDOWS)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .ref_div_i    (ref_div_i[ch]),
            .clear_loss_i (clear_loss_i[ch]),
            .win_end_i    (win_end),
            .locked_o     (locked_o[ch]),
            .loss_o       (loss_o[ch]),
            .freq_count_o (freq_count_o[ch*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_xcvr_ref_clk_monitor.sv
// tb/tb_xcvr_ref_clk_monitor.sv - randomized self-checking bench for xcvr_ref_clk_monitor
module tb_xcvr_ref_clk_monitor;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int W      = 1024;
    localparam int EXP    = 16;
    localparam int TOL    = 1;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_CH-1:0]       ref_div = '0;
    logic [NUM_CH-1:0]       clr = '0;
    logic [NUM_CH-1:0]       locked;
    logic [NUM_CH-1:0]       loss;
    logic [NUM_CH*CNT_W-1:0] freq;
    logic                    cvalid;

    xcvr_ref_clk_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WINDOW_CYCLES(W), .EXP_COUNT(EXP),
        .TOL(TOL), .LOCK_WINDOWS(LOCK_N), .LOSS_WINDOWS(LOSS_N)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ref_div_i(ref_div), .clear_loss_i(clr),
        .locked_o(locked), .loss_o(loss), .freq_count_o(freq), .count_valid_o(cvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    bit run_checks = 0;
    bit rand_clr = 0;
    int per [NUM_CH];
    int off [NUM_CH];
    int plist [8] = '{64, 62, 66, 68, 60, 48, 80, 0};

    // Reference model: cycle index since reset release, edges bucketed by the window they are detected in.
    int cyc;
    bit prev [NUM_CH];
    int cur [NUM_CH];
    int nxt [NUM_CH];
    bit m_locked [NUM_CH];
    bit m_loss [NUM_CH];
    int m_good [NUM_CH];
    int m_bad [NUM_CH];
    int exp_freq [NUM_CH];
    bit exp_valid;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    task automatic model_step();
        int c;
        bit inr;
        bit set_loss;
        if (rst) begin
            cyc = 0;
            exp_valid = 0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                prev[ch] = 0; cur[ch] = 0; nxt[ch] = 0;
                m_locked[ch] = 0; m_loss[ch] = 0; m_good[ch] = 0; m_bad[ch] = 0;
                exp_freq[ch] = 0;
            end
            return;
        end
        exp_valid = (cyc % W == W - 1);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            // A rising sample taken at cycle j is counted two cycles later.
            if (ref_div[ch] && !prev[ch]) begin
                if ((cyc + 2) / W == cyc / W) cur[ch]++;
                else nxt[ch]++;
            end
            prev[ch] = ref_div[ch];
            set_loss = 0;
            if (exp_valid) begin
                c = (cur[ch] > CMAX) ? CMAX : cur[ch];
                exp_freq[ch] = c;
                inr = (c >= ((EXP > TOL) ? EXP - TOL : 0)) && (c <= EXP + TOL);
                if (!m_locked[ch]) begin
                    if (inr) begin
                        m_good[ch]++;
                        if (m_good[ch] >= LOCK_N) begin m_locked[ch] = 1; m_bad[ch] = 0; end
                    end else m_good[ch] = 0;
                end else if (c == 0) begin
                    m_locked[ch] = 0; m_good[ch] = 0; m_bad[ch] = 0; set_loss = 1;
                end else if (inr) begin
                    m_bad[ch] = 0;
                end else begin
                    m_bad[ch]++;
                    if (m_bad[ch] >= LOSS_N) begin
                        m_locked[ch] = 0; m_good[ch] = 0; m_bad[ch] = 0; set_loss = 1;
                    end
                end
                cur[ch] = nxt[ch];
                nxt[ch] = 0;
            end
            if (set_loss) m_loss[ch] = 1;
            else if (clr[ch]) m_loss[ch] = 0;
        end
        cyc++;
    endtask

    task automatic compare_outputs();
        logic [NUM_CH-1:0]       el;
        logic [NUM_CH-1:0]       es;
        logic [NUM_CH*CNT_W-1:0] ef;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            el[ch] = m_locked[ch];
            es[ch] = m_loss[ch];
            ef[ch*CNT_W +: CNT_W] = CNT_W'(exp_freq[ch]);
        end
        check("model_locked", locked, el);
        check("model_loss", loss, es);
        check("model_count_valid", cvalid, exp_valid);
        check("model_freq_count", freq, ef);
    endtask

    always @(posedge clk or posedge rst) model_step();

    always @(negedge clk) if (run_checks) compare_outputs();

    task automatic step();
        @(negedge clk);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ref_div[ch] = (per[ch] > 0) && (((cyc + off[ch]) % per[ch]) < per[ch] / 2);
            if (rand_clr) clr[ch] = ($urandom_range(0, 299) == 0);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        per = '{64, 64};
        off = '{3, 10};
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_loss", loss, 0);
        check("rst_freq", freq, 0);
        check("rst_valid", cvalid, 0);
        rst = 1'b0;
        run_checks = 1;

        run_to(3 * W);
        check("no_lock_after_3", locked, 0);
        run_to(4 * W);
        check("valid_w4", cvalid, 1);
        check("lock_after_4", locked, 2'b11);
        check("freq0_w4", freq[15:0], 16);
        check("freq1_w4", freq[31:16], 16);
        check("loss_w4", loss, 0);

        // ch1 stops; clear requested on the very cycle its loss is set.
        per[1] = 0;
        run_to(5 * W - 1);
        clr = 2'b10;
        step();
        clr = 2'b00;
        check("stop_valid", cvalid, 1);
        check("stop_freq1", freq[31:16], 0);
        check("stop_locked", locked, 2'b01);
        check("set_beats_clear", loss, 2'b10);
        repeat (5) step();
        clr = 2'b10;
        step();
        clr = 2'b00;
        check("clear_loss", loss, 2'b00);
        run_to(6 * W);
        per[1] = 64;

        per[0] = 48; run_to(7 * W);
        per[0] = 64; run_to(9 * W);
        per[0] = 48; run_to(11 * W);

        rand_clr = 1;
        for (int w = 0; w < 40; w++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                per[ch] = plist[$urandom_range(0, 7)];
                off[ch] = $urandom_range(0, 127);
            end
            run_to(cyc - (cyc % W) + W);
        end
        rand_clr = 0;
        clr = '0;

        per = '{64, 64};
        off = '{3, 10};
        run_to(cyc - (cyc % W) + 5 * W);
        check("relock_before_rst", locked, 2'b11);
        run_to(cyc + W / 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_locked", locked, 0);
        check("async_rst_valid", cvalid, 0);
        check("async_rst_freq", freq, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_to(3 * W);
        check("post_rst_no_lock", locked, 0);
        run_to(4 * W);
        check("post_rst_lock", locked, 2'b11);

        @(negedge clk);
        run_checks = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
